l1_bus_arb: RTL and testbench

L1_BUS_ARB -- requirements
Module: l1_bus_arb

---
 rtl/l1_bus_arb_pkg.sv | 16 +
 rtl/l1_bus_arb_if.sv | 40 ++++
 rtl/l1_bus_arb_rr_arb2.sv | 24 ++
 rtl/l1_bus_arb.sv | 103 ++++++++++
 tb/tb_l1_bus_arb.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/l1_bus_arb_pkg.sv
// Shared L1/L2 bus configuration: cache line geometry and the arbiter state encoding.
package l1_bus_arb_pkg;

  localparam int unsigned IMEM_LINE    = 128;
  localparam int unsigned IMEM_BLK_LEN = 26;
  localparam int unsigned DMEM_LINE    = 128;
  localparam int unsigned DMEM_BLK_LEN = 26;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ_I = 2'd1,
    REQ_D = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/l1_bus_arb_if.sv
// Bus bundle between the two L1 caches, the arbiter and L2.
interface l1_bus_arb_if
  import l1_bus_arb_pkg::*;
#(
  parameter int unsigned LINE    = IMEM_LINE,
  parameter int unsigned BLK_LEN = IMEM_BLK_LEN
);

  logic [BLK_LEN-1:0] b_addr_i;
  logic               b_rd_i;
  logic [LINE-1:0]    b_data_i;
  logic               b_dv_i;

  logic [BLK_LEN-1:0] b_addr_d;
  logic               b_rd_d;
  logic               b_wr_d;
  logic [LINE-1:0]    b_wdata_d;
  logic [LINE-1:0]    b_data_d;
  logic               b_dv_d;

  logic [BLK_LEN-1:0] l2_addr;
  logic               l2_rd;
  logic               l2_wr;
  logic [LINE-1:0]    l2_wdata;
  logic [LINE-1:0]    l2_rdata;
  logic               l2_ack;

  // Arbiter view
  modport master (
    input  b_addr_i, b_rd_i, b_addr_d, b_rd_d, b_wr_d, b_wdata_d, l2_rdata, l2_ack,
    output b_data_i, b_dv_i, b_data_d, b_dv_d, l2_addr, l2_rd, l2_wr, l2_wdata
  );

  // Caches plus L2 view
  modport slave (
    output b_addr_i, b_rd_i, b_addr_d, b_rd_d, b_wr_d, b_wdata_d, l2_rdata, l2_ack,
    input  b_data_i, b_dv_i, b_data_d, b_dv_d, l2_addr, l2_rd, l2_wr, l2_wdata
  );

endinterface

// File: rtl/l1_bus_arb_rr_arb2.sv
// Two-way round-robin selector; req[0] is the I-cache, req[1] the D-cache.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic pri_d;

  always_comb begin
    gnt = '0;
    if (req[1] && (!req[0] || pri_d)) gnt[1] = 1'b1;
    else if (req[0])                  gnt[0] = 1'b1;
  end

  // Only a contested grant moves the pointer, so an uncontested grant never steals the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              pri_d <= 1'b1;
    else if (adv && (&req))  pri_d <= gnt[0];
  end

endmodule

// File: rtl/l1_bus_arb.sv
// Arbitrates I-cache refills and D-cache refills/writebacks onto a single-outstanding L2 port.
module l1_bus_arb
  import l1_bus_arb_pkg::*;
#(
  parameter int unsigned LINE    = IMEM_LINE,
  parameter int unsigned BLK_LEN = IMEM_BLK_LEN
) (
  input logic         clk,
  input logic         rst_n,
  l1_bus_arb_if.master bus
);

  if (DMEM_LINE != IMEM_LINE) begin : g_line_chk
    $error("DMEM_LINE must equal IMEM_LINE");
  end

  state_t             state, state_nx;
  logic [BLK_LEN-1:0] addr_q;
  logic [LINE-1:0]    wdata_q;
  logic [LINE-1:0]    rdata_q;
  logic               l2_rd_q;
  logic               l2_wr_q;
  logic               sel_d_q;
  logic [1:0]         req;
  logic [1:0]         gnt;
  logic               adv;

  assign req = {bus.b_rd_d | bus.b_wr_d, bus.b_rd_i};
  assign adv = (state == IDLE);

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .adv   (adv),
    .gnt   (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (gnt[1])      state_nx = REQ_D;
        else if (gnt[0]) state_nx = REQ_I;
      end
      REQ_I, REQ_D: if (bus.l2_ack) state_nx = RESP;
      RESP:         state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      l2_rd_q <= 1'b0;
      l2_wr_q <= 1'b0;
      sel_d_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // A D-side write wins over a simultaneous D-side read; the read stays pending.
          if (gnt[1]) begin
            addr_q  <= bus.b_addr_d;
            wdata_q <= bus.b_wdata_d;
            l2_rd_q <= ~bus.b_wr_d;
            l2_wr_q <= bus.b_wr_d;
            sel_d_q <= 1'b1;
          end else if (gnt[0]) begin
            addr_q  <= bus.b_addr_i;
            l2_rd_q <= 1'b1;
            l2_wr_q <= 1'b0;
            sel_d_q <= 1'b0;
          end
        end
        REQ_I, REQ_D: begin
          if (bus.l2_ack) begin
            rdata_q <= bus.l2_rdata;
            l2_rd_q <= 1'b0;
            l2_wr_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.l2_addr  = addr_q;
  assign bus.l2_wdata = wdata_q;
  assign bus.l2_rd    = l2_rd_q;
  assign bus.l2_wr    = l2_wr_q;
  assign bus.b_data_i = rdata_q;
  assign bus.b_data_d = rdata_q;
  assign bus.b_dv_i   = (state == RESP) && !sel_d_q;
  assign bus.b_dv_d   = (state == RESP) &&  sel_d_q;

endmodule

// File: tb/tb_l1_bus_arb.sv
// Directed bench for l1_bus_arb: a vector table of single transactions plus hand sequences.
module tb_l1_bus_arb;
  import l1_bus_arb_pkg::*;

  localparam int unsigned L = IMEM_LINE;
  localparam int unsigned B = IMEM_BLK_LEN;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  l1_bus_arb_if #(.LINE(L), .BLK_LEN(B)) bus ();

  l1_bus_arb #(.LINE(L), .BLK_LEN(B)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string        name;
    bit           rd_i;
    bit           rd_d;
    bit           wr_d;
    logic [B-1:0] addr;
    logic [L-1:0] wdata;
    logic [L-1:0] rdata;
    int           delay;
    bit           exp_d;
    bit           exp_wr;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [L-1:0] act, input logic [L-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string nm);
    chk({nm, " strobes"}, L'({bus.l2_rd, bus.l2_wr, bus.b_dv_i, bus.b_dv_d}), L'(0));
    chk({nm, " state"}, L'(dut.state), L'(IDLE));
  endtask

  // Waits for the L2 strobe, checks it, acks after 'delay' strobe cycles and checks the dv pulse.
  task automatic l2_txn(input string nm, input int delay, input logic [L-1:0] rdata,
                        input bit exp_d, input bit exp_wr,
                        input logic [B-1:0] exp_addr, input logic [L-1:0] exp_wdata);
    int           w;
    bit           stable;
    logic [B-1:0] sv_ai, sv_ad;
    logic [1:0]   dir;
    dir = exp_wr ? 2'b01 : 2'b10;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!(bus.l2_rd || bus.l2_wr) && w < 20);
    if (!(bus.l2_rd || bus.l2_wr)) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: no L2 strobe after %0d cycles, required one", nm, w);
      return;
    end
    chk({nm, " lat"}, L'(w), L'(1));
    chk({nm, " dir"}, L'({bus.l2_rd, bus.l2_wr}), L'(dir));
    chk({nm, " addr"}, L'(bus.l2_addr), L'(exp_addr));
    if (exp_wr) chk({nm, " wdata"}, bus.l2_wdata, exp_wdata);
    stable = 1'b1;
    sv_ai = bus.b_addr_i;
    sv_ad = bus.b_addr_d;
    repeat (delay) begin
      bus.b_addr_i = B'($urandom);
      bus.b_addr_d = B'($urandom);
      @(negedge clk);
      if (bus.l2_addr !== exp_addr || {bus.l2_rd, bus.l2_wr} !== dir ||
          (exp_wr && bus.l2_wdata !== exp_wdata) || bus.b_dv_i || bus.b_dv_d)
        stable = 1'b0;
    end
    bus.b_addr_i = sv_ai;
    bus.b_addr_d = sv_ad;
    if (delay > 0) chk({nm, " hold"}, L'(stable), L'(1));
    bus.l2_rdata = rdata;
    bus.l2_ack   = 1'b1;
    @(negedge clk);
    bus.l2_ack   = 1'b0;
    bus.l2_rdata = ~rdata;
    chk({nm, " dv"}, L'({bus.b_dv_d, bus.b_dv_i}), L'(exp_d ? 2'b10 : 2'b01));
    if (!exp_wr) begin
      chk({nm, " data_i"}, bus.b_data_i, rdata);
      chk({nm, " data_d"}, bus.b_data_d, rdata);
    end
    chk({nm, " drop"}, L'({bus.l2_rd, bus.l2_wr}), L'(0));
    if (exp_d) begin
      if (exp_wr) bus.b_wr_d = 1'b0;
      else        bus.b_rd_d = 1'b0;
    end else begin
      bus.b_rd_i = 1'b0;
    end
    @(negedge clk);
    chk({nm, " pulse"}, L'({bus.b_dv_d, bus.b_dv_i}), L'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"i_rd_12",  1, 0, 0, B'('h12), '0,            {(L/8){8'hA5}}, 1, 0, 0};
    vecs[1] = '{"d_rd_03",  0, 1, 0, B'('h03), '0,            {(L/16){16'h0123}}, 0, 1, 0};
    vecs[2] = '{"d_wr_2a",  0, 0, 1, B'('h2A), {(L/8){8'h5A}}, '0,            2, 1, 1};
    vecs[3] = '{"i_rd_max", 1, 0, 0, '1,       '0,            '1,            0, 0, 0};
    vecs[4] = '{"d_wr_0",   0, 0, 1, '0,       {(L/8){8'hC3}}, {(L/8){8'h11}}, 3, 1, 1};

    rst_n         = 1'b0;
    bus.b_addr_i  = '0;
    bus.b_rd_i    = 1'b0;
    bus.b_addr_d  = '0;
    bus.b_rd_d    = 1'b0;
    bus.b_wr_d    = 1'b0;
    bus.b_wdata_d = '0;
    bus.l2_rdata  = '0;
    bus.l2_ack    = 1'b0;

    repeat (2) @(negedge clk);
    chk_idle_outputs("reset");
    chk("reset addr", L'(bus.l2_addr), L'(0));
    chk("reset wdata", bus.l2_wdata, '0);
    chk("reset data", bus.b_data_i | bus.b_data_d, '0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      bus.b_addr_i  = vecs[i].addr;
      bus.b_addr_d  = vecs[i].addr;
      bus.b_wdata_d = vecs[i].wdata;
      bus.b_rd_i    = vecs[i].rd_i;
      bus.b_rd_d    = vecs[i].rd_d;
      bus.b_wr_d    = vecs[i].wr_d;
      l2_txn(vecs[i].name, vecs[i].delay, vecs[i].rdata, vecs[i].exp_d, vecs[i].exp_wr,
             vecs[i].addr, vecs[i].wdata);
    end

    // Round robin from reset: D first, then I; next tie goes to I.
    do_reset();
    bus.b_addr_i = B'('h21);
    bus.b_addr_d = B'('h31);
    bus.b_rd_i = 1'b1;
    bus.b_rd_d = 1'b1;
    l2_txn("rr1_d", 0, {(L/8){8'hD1}}, 1, 0, B'('h31), '0);
    l2_txn("rr1_i", 0, {(L/8){8'hE1}}, 0, 0, B'('h21), '0);
    bus.b_rd_i = 1'b1;
    bus.b_rd_d = 1'b1;
    l2_txn("rr2_i", 0, {(L/8){8'hE2}}, 0, 0, B'('h21), '0);
    l2_txn("rr2_d", 0, {(L/8){8'hD2}}, 1, 0, B'('h31), '0);

    // Simultaneous D write and read: write first, read follows.
    bus.b_addr_d  = B'('h77);
    bus.b_wdata_d = {(L/8){8'h5A}};
    bus.b_rd_d    = 1'b1;
    bus.b_wr_d    = 1'b1;
    l2_txn("wr_first", 1, {(L/8){8'h99}}, 1, 1, B'('h77), {(L/8){8'h5A}});
    l2_txn("rd_after", 0, {(L/8){8'h3C}}, 1, 0, B'('h77), '0);

    // Slow L2: strobe and address held for 20 cycles.
    bus.b_addr_i = B'('h4F);
    bus.b_rd_i   = 1'b1;
    l2_txn("slow_l2", 20, {(L/8){8'h6B}}, 0, 0, B'('h4F), '0);

    // Reset mid-REQ_I followed by a late ack.
    bus.b_addr_i = B'('h44);
    bus.b_rd_i   = 1'b1;
    @(negedge clk);
    chk("mid_rst strobe", L'(bus.l2_rd), L'(1));
    #2 rst_n = 1'b0;
    #1 chk("mid_rst async", L'({bus.l2_rd, bus.l2_wr, bus.b_dv_i, bus.b_dv_d}), L'(0));
    bus.b_rd_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.l2_ack = 1'b1;
    @(negedge clk);
    bus.l2_ack = 1'b0;
    begin
      bit quiet = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (bus.b_dv_i || bus.b_dv_d || bus.l2_rd || bus.l2_wr) quiet = 1'b0;
      end
      chk("late_ack quiet", L'(quiet), L'(1));
    end
    chk_idle_outputs("late_ack");

    // Stray ack in IDLE.
    bus.l2_ack = 1'b1;
    @(negedge clk);
    bus.l2_ack = 1'b0;
    chk_idle_outputs("stray_ack");
    @(negedge clk);
    chk_idle_outputs("stray_ack2");

    bus.b_addr_d = B'('h05);
    bus.b_rd_d   = 1'b1;
    l2_txn("post_stray", 0, {(L/8){8'h81}}, 1, 0, B'('h05), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
